alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execution-side consumer of the 3-bit ALU_Cnt code produced by the ALU control decoder.
- Takes two operands and an ALU_Cnt code through a start/busy/done handshake, and returns a registered Result and Zero flag.
- Add, subtract, logic and set-less-than complete in one cycle. Shifts run iteratively, one bit per cycle, so the datapath carries no barrel shifter.
- Sits between the register-file read stage and writeback of the multi-cycle RISC-V core.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, $clog2(WIDTH), shift-amount width; shamt = B[SHW-1:0].

Ports:
- clk      input   1      system clock, rising edge.
- rst_n    input   1      reset.
- start    input   1      request; sampled only when busy=0.
- ALU_Cnt  input   3      operation code.
- A        input   WIDTH  operand A / shift source.
- B        input   WIDTH  operand B; low SHW bits are the shift amount.
- busy     output  1      iterative shift in progress; start ignored.
- done     output  1      one-cycle pulse; Result/Zero valid from this cycle.
- Result   output  WIDTH  registered result; held until next done.
- Zero     output  1      registered (Result == 0).

Interface note: one clock; reset is synchronous and active-low.

Behaviour:
- Encoding (package constants):
  - 000 ADD: A+B, wraps mod 2^WIDTH.
  - 001 SUB: A-B, wraps.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: A << shamt, zero fill.
  - 110 SRL: A >> shamt, zero fill.
  - 111 SLT: signed A<B gives 1, else 0, zero-extended.
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, Result=0, Zero=1, shift counter=0. Reset overrides any in-flight shift, and any start in the same cycle is dropped.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 at an edge while in IDLE or DONE (busy=0).
  - Non-shift op, or shift with shamt=0: Result/Zero loaded at the accept edge, next state DONE. Latency is 1 edge.
  - Shift with shamt>0: accumulator=A, cnt=shamt, next state SHIFT.
- SHIFT: busy=1. Each edge shifts the accumulator by 1 in the coded direction and decrements cnt. When cnt==1, that edge writes the final value to Result/Zero and moves to DONE. The state lasts exactly shamt cycles, so done asserts 1+shamt edges after accept.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in DONE is accepted (back-to-back, no bubble).
  - Otherwise the block returns to IDLE.
- start while busy=1: ignored, no queuing. ALU_Cnt/A/B are don't-care after accept; operands are captured at the accept edge.
- Result and Zero change only at the done-producing edge and hold stable otherwise.
- A partially shifted accumulator is never visible on Result.
- Zero is computed from the value being written to Result, never from stale data.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU_Cnt localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT.
  - State encoding: ST_IDLE, ST_SHIFT, ST_DONE.
  - The ALU control decoder imports the same package so the two ends cannot drift.
- One sub-module, alu_comb_core: purely combinational single-cycle ops (ADD/SUB/AND/OR/XOR/SLT).
- The FSM, shift accumulator/counter and output registers stay in alu_seq_exec.

Test Plan:
- ADD: A=5, B=7, start pulse from IDLE. Response: done on the next cycle, Result=12, Zero=0, busy never high.
- SUB then SLT, back-to-back:
  - A=9, B=9, SUB gives Result=0, Zero=1.
  - start held during the DONE cycle with SLT, A=0xFFFFFFFF, B=1. Response: Result=1 one cycle later, no idle bubble.
- SLL with A=1, B=4. Response:
  - busy high for exactly 4 cycles.
  - done on edge 5 after accept, Result=16.
  - Result unchanged (previous value) during busy.
- SRL with A=0x80000000, B=0x23. Response:
  - shamt=3 (upper B bits ignored), Result=0x10000000 after 4 edges.
  - start/ALU_Cnt=ADD pulsed mid-shift is ignored and produces no extra done.
- Shift with shamt=0: SLL, A=0xA5, B=0x20. Response: 1-cycle latency, busy never high, Result=0xA5.
- Reset mid-shift: rst_n=0 for one edge during an SLL with B=10. Response:
  - next cycle busy=0, done=0, Result=0, Zero=1, and no done for the aborted op.
  - a new ADD 2+3 then returns 5.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU_Cnt encoding and sequencer state codes for the ALU control decoder
// and the execution unit, so both ends of the ALU_Cnt bus agree.
package alu_ctrl_pkg;

   localparam int ALU_CNT_W = 3;

   typedef logic [ALU_CNT_W-1:0] alu_cnt_t;

   localparam alu_cnt_t ALU_ADD = 3'b000;
   localparam alu_cnt_t ALU_SUB = 3'b001;
   localparam alu_cnt_t ALU_AND = 3'b010;
   localparam alu_cnt_t ALU_OR  = 3'b011;
   localparam alu_cnt_t ALU_XOR = 3'b100;
   localparam alu_cnt_t ALU_SLL = 3'b101;
   localparam alu_cnt_t ALU_SRL = 3'b110;
   localparam alu_cnt_t ALU_SLT = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Shifts are the only codes that may take the multi-cycle path.
   function automatic logic is_shift(input alu_cnt_t op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the issuing stage (master) and the
// sequential ALU (slave).
interface alu_seq_exec_if
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start;
   alu_cnt_t         ALU_Cnt;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Result;
   logic             Zero;

   modport master (
      output start, ALU_Cnt, A, B,
      input  busy, done, Result, Zero
   );

   modport slave (
      input  start, ALU_Cnt, A, B,
      output busy, done, Result, Zero
   );

endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations; shift codes produce zero here because
// the sequencer handles them itself.
module alu_comb_core
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_cnt_t         op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic lt;

   assign lt = ($signed(a) < $signed(b));

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_SLT: y = {{(WIDTH-1){1'b0}}, lt};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU: one-cycle arithmetic/logic, one-bit-per-cycle shifts,
// with a start/busy/done handshake and registered Result/Zero.
module alu_seq_exec
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_exec_if.slave bus
);

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic             dir_left;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;

   logic [SHW-1:0]   shamt;
   logic             shift_op;
   logic             accept;
   logic [WIDTH-1:0] comb_y;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] shift_next;

   alu_comb_core #(
      .WIDTH (WIDTH)
   ) u_comb (
      .op (bus.ALU_Cnt),
      .a  (bus.A),
      .b  (bus.B),
      .y  (comb_y)
   );

   assign shamt    = bus.B[SHW-1:0];
   assign shift_op = is_shift(bus.ALU_Cnt);
   assign accept   = bus.start && (state != ST_SHIFT);

   // A zero-distance shift takes the one-cycle path with A passed through.
   assign load_val   = shift_op ? bus.A : comb_y;
   assign shift_next = dir_left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};

   // The accumulator stays private; Result is written only on the done-producing edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         acc      <= '0;
         cnt      <= '0;
         dir_left <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         case (state)
            ST_SHIFT: begin
               acc <= shift_next;
               cnt <= cnt - 1'b1;
               if (cnt == SHW'(1)) begin
                  result_q <= shift_next;
                  zero_q   <= (shift_next == '0);
                  state    <= ST_DONE;
               end
            end
            default: begin
               if (accept) begin
                  if (shift_op && (shamt != '0)) begin
                     acc      <= bus.A;
                     cnt      <= shamt;
                     dir_left <= (bus.ALU_Cnt == ALU_SLL);
                     state    <= ST_SHIFT;
                  end else begin
                     result_q <= load_val;
                     zero_q   <= (load_val == '0);
                     state    <= ST_DONE;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy   = (state == ST_SHIFT);
   assign bus.done   = (state == ST_DONE);
   assign bus.Result = result_q;
   assign bus.Zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed table, handshake corner
// sequences and random operations against a behavioural model.
module tb_alu_seq_exec;
   import alu_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   compared;
   int   failed;

   alu_seq_exec_if #(.WIDTH(32)) bus ();

   alu_seq_exec #(
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_result;
      logic        exp_zero;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   // Reference behaviour written from the operation table itself.
   function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << sh;
         3'd6: return a >> sh;
         default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] op, input logic [31:0] b);
      if (op == 3'd5 || op == 3'd6) return int'(b % 32);
      return 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.ALU_Cnt = op;
      bus.A       = a;
      bus.B       = b;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.ALU_Cnt = 3'($urandom);
      bus.A       = $urandom;
      bus.B       = $urandom;
   endtask

   // Issue one operation and check latency, busy length, Result stability and the done pulse.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                         input int exp_lat);
      logic [31:0] prev;
      int          lat;
      int          busy_n;
      int          unstable;
      prev     = bus.Result;
      applyStimulus(op, a, b);
      lat      = 0;
      busy_n   = 0;
      unstable = 0;
      while (!bus.done && lat < 64) begin
         if (bus.busy) busy_n++;
         if (bus.Result !== prev) unstable++;
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, " done"}, 32'(bus.done), 32'd1);
      checkOutput({name, " result"}, bus.Result, exp_res);
      checkOutput({name, " zero"}, 32'(bus.Zero), 32'(exp_zero));
      checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
      checkOutput({name, " result held while busy"}, 32'(unstable), 32'd0);
      checkOutput({name, " busy at done"}, 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({name, " done pulse ends"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          dones;
      int          done_at;
      logic [31:0] seen;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      compared    = 0;
      failed      = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.ALU_Cnt = ALU_ADD;
      bus.A       = '0;
      bus.B       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset done", 32'(bus.done), 32'd0);
      checkOutput("reset result", bus.Result, 32'd0);
      checkOutput("reset zero", 32'(bus.Zero), 32'd1);
      rst_n = 1'b1;

      vecs.push_back('{"add 5+7",        ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 0});
      vecs.push_back('{"add wrap",       ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 0});
      vecs.push_back('{"sub 3-5",        ALU_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 0});
      vecs.push_back('{"and",            ALU_AND, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 0});
      vecs.push_back('{"or",             ALU_OR,  32'hA000_0005,  32'h0500_0050,  32'hA500_0055,  1'b0, 0});
      vecs.push_back('{"xor self",       ALU_XOR, 32'h1234_5678,  32'h1234_5678,  32'd0,          1'b1, 0});
      vecs.push_back('{"slt pos<neg",    ALU_SLT, 32'd5,          32'hFFFF_FFFF,  32'd0,          1'b1, 0});
      vecs.push_back('{"slt neg<pos",    ALU_SLT, 32'h8000_0000,  32'd0,          32'd1,          1'b0, 0});
      vecs.push_back('{"sll 1<<4",       ALU_SLL, 32'd1,          32'd4,          32'd16,         1'b0, 4});
      vecs.push_back('{"srl shamt 3",    ALU_SRL, 32'h8000_0000,  32'h23,         32'h1000_0000,  1'b0, 3});
      vecs.push_back('{"sll shamt 0",    ALU_SLL, 32'hA5,         32'h20,         32'hA5,         1'b0, 0});
      vecs.push_back('{"srl to zero",    ALU_SRL, 32'd1,          32'd1,          32'd0,          1'b1, 1});
      vecs.push_back('{"sll max",        ALU_SLL, 32'd3,          32'd31,         32'h8000_0000,  1'b0, 31});

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp_result, vecs[i].exp_zero, vecs[i].exp_lat);

      // Back-to-back: start held through the DONE cycle is accepted with no bubble.
      @(negedge clk);
      bus.start = 1'b1; bus.ALU_Cnt = ALU_SUB; bus.A = 32'd9; bus.B = 32'd9;
      @(posedge clk);
      #1;
      checkOutput("b2b sub done", 32'(bus.done), 32'd1);
      checkOutput("b2b sub result", bus.Result, 32'd0);
      checkOutput("b2b sub zero", 32'(bus.Zero), 32'd1);
      bus.ALU_Cnt = ALU_SLT; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("b2b slt done", 32'(bus.done), 32'd1);
      checkOutput("b2b slt result", bus.Result, 32'd1);
      checkOutput("b2b slt zero", 32'(bus.Zero), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("b2b done ends", 32'(bus.done), 32'd0);

      // A start during a shift is ignored and must not produce a second done.
      applyStimulus(ALU_SRL, 32'h8000_0000, 32'h23);
      dones   = 0;
      done_at = -1;
      seen    = '0;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin
            bus.start = 1'b1; bus.ALU_Cnt = ALU_ADD; bus.A = 32'd1; bus.B = 32'd1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.done) begin
            dones++;
            if (dones == 1) begin
               done_at = i + 1;
               seen    = bus.Result;
            end
         end
      end
      checkOutput("ignored start done count", 32'(dones), 32'd1);
      checkOutput("ignored start latency", 32'(done_at), 32'd3);
      checkOutput("ignored start result", seen, 32'h1000_0000);

      // Reset in the middle of a shift aborts it and drops a coincident start.
      applyStimulus(ALU_SLL, 32'd1, 32'd10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      bus.start = 1'b1; bus.ALU_Cnt = ALU_ADD; bus.A = 32'd7; bus.B = 32'd7;
      @(posedge clk);
      #1;
      checkOutput("abort busy", 32'(bus.busy), 32'd0);
      checkOutput("abort done", 32'(bus.done), 32'd0);
      checkOutput("abort result", bus.Result, 32'd0);
      checkOutput("abort zero", 32'(bus.Zero), 32'd1);
      rst_n     = 1'b1;
      bus.start = 1'b0;
      dones     = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      checkOutput("abort no done", 32'(dones), 32'd0);
      run_op("add after abort", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 3) == 0) rb = ra;
         run_op($sformatf("random %0d op %0d", n, rop), rop, ra, rb,
                model_result(rop, ra, rb), (model_result(rop, ra, rb) == 32'd0),
                model_latency(rop, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
